// File: rtl/add_sub_pkg.sv
// Shared opcode encoding and index-width helper for the bit-serial add/sub unit.
package add_sub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bit-index counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_sub_1bit_if.sv
// Serial operand/result bundle for add_sub_1bit; ovf_out exists only with ADD_SUB_OVF_EN.
interface add_sub_1bit_if;
  logic valid_in;
  logic first_in;
  logic a_in;
  logic b_in;
  logic opcode;
  logic sum_out;
  logic flag_out;
  logic valid_out;
  logic last_out;
`ifdef ADD_SUB_OVF_EN
  logic ovf_out;

  modport master (
    output valid_in, first_in, a_in, b_in, opcode,
    input  sum_out, flag_out, valid_out, last_out, ovf_out
  );
  modport slave (
    input  valid_in, first_in, a_in, b_in, opcode,
    output sum_out, flag_out, valid_out, last_out, ovf_out
  );
`else
  modport master (
    output valid_in, first_in, a_in, b_in, opcode,
    input  sum_out, flag_out, valid_out, last_out
  );
  modport slave (
    input  valid_in, first_in, a_in, b_in, opcode,
    output sum_out, flag_out, valid_out, last_out
  );
`endif
endinterface

// File: rtl/add_sub_1bit_cell.sv
// Combinational 1-bit full adder / full subtractor (borrow form A-B-c).
module add_sub_cell
  import add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  op_e  op,
  output logic res,
  output logic cflag
);

  always_comb begin
    res = a ^ b ^ c;
    if (op == OP_SUB) cflag = (~a & b) | (~a & c) | (b & c);
    else              cflag = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/add_sub_1bit.sv
// Bit-serial adder/subtractor, LSB-first, registered carry/borrow and outputs.
// Optional signed-overflow output on the MSB beat is enabled by ADD_SUB_OVF_EN.
module add_sub_1bit
  import add_sub_pkg::*;
#(
  parameter int unsigned WORD_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  add_sub_1bit_if.slave bus
);

  localparam int unsigned      IDX_W    = idx_width(WORD_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BITS - 1);

  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] next_idx;
  logic             carry_q;
  op_e              op_q;
  logic             word_start;
  logic             is_last;
  logic             c_in;
  op_e              op_cur;
  logic             res;
  logic             cflag;
  logic             sum_q;
  logic             flag_q;
  logic             valid_q;
  logic             last_q;

  // first_in mid-word restarts at index 0, so the current bit's index is forced.
  always_comb begin
    word_start = bus.first_in | (bit_idx == '0);
    cur_idx    = bus.first_in ? '0 : bit_idx;
    is_last    = (cur_idx == LAST_IDX);
    next_idx   = is_last ? '0 : cur_idx + IDX_W'(1);
    c_in       = word_start ? 1'b0 : carry_q;
    op_cur     = word_start ? op_e'(bus.opcode) : op_q;
  end

  add_sub_cell u_cell (
    .a     (bus.a_in),
    .b     (bus.b_in),
    .c     (c_in),
    .op    (op_cur),
    .res   (res),
    .cflag (cflag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      sum_q   <= 1'b0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      last_q  <= bus.valid_in & is_last;
      if (bus.valid_in) begin
        sum_q   <= res;
        flag_q  <= cflag;
        carry_q <= cflag;
        op_q    <= op_cur;
        bit_idx <= next_idx;
      end
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.flag_out  = flag_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;

`ifdef ADD_SUB_OVF_EN
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    if (op_cur == OP_SUB) ovf_d = (bus.a_in != bus.b_in) & (res != bus.a_in);
    else                  ovf_d = (bus.a_in == bus.b_in) & (res != bus.a_in);
    ovf_d = ovf_d & is_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (bus.valid_in) ovf_q <= ovf_d;
  end

  assign bus.ovf_out = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_1bit.sv
// Directed self-checking bench for add_sub_1bit (WORD_BITS=1 and WORD_BITS=8 instances).
module tb_add_sub_1bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  add_sub_1bit_if bus1 ();
  add_sub_1bit_if bus8 ();

  add_sub_1bit #(.WORD_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  add_sub_1bit #(.WORD_BITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step8(input logic v, input logic f, input logic a, input logic b, input logic op);
    @(negedge clk);
    bus8.valid_in = v;
    bus8.first_in = f;
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.opcode   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic op, input logic lead_first,
                          input logic [7:0] es, input logic ef, input logic eo);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, (i == 0) & lead_first, a[i], b[i], op);
      chk({tag, "_valid"}, bus8.valid_out, 1);
      chk({tag, "_last"}, bus8.last_out, (i == 7));
      got[i] = bus8.sum_out;
    end
    chk({tag, "_sum"}, got, es);
    chk({tag, "_flag"}, bus8.flag_out, ef);
`ifdef ADD_SUB_OVF_EN
    chk({tag, "_ovf"}, bus8.ovf_out, eo);
`else
    if (eo === 1'bx) chk({tag, "_ovf_arg"}, eo, 0);
`endif
    step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_idle_valid"}, bus8.valid_out, 0);
    chk({tag, "_idle_last"}, bus8.last_out, 0);
  endtask

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] flag_tab;
    logic [7:0] got;
    int         idx;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    {bus1.valid_in, bus1.first_in, bus1.a_in, bus1.b_in, bus1.opcode} = '0;
    {bus8.valid_in, bus8.first_in, bus8.a_in, bus8.b_in, bus8.opcode} = '0;

    #3;
    chk("rst1_sum", bus1.sum_out, 0);
    chk("rst1_valid", bus1.valid_out, 0);
    chk("rst8_sum", bus8.sum_out, 0);
    chk("rst8_flag", bus8.flag_out, 0);
    chk("rst8_valid", bus8.valid_out, 0);
    chk("rst8_last", bus8.last_out, 0);
`ifdef ADD_SUB_OVF_EN
    chk("rst8_ovf", bus8.ovf_out, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // WORD_BITS=1 truth table, indexed by {op,a,b}
    sum_tab  = 8'b0110_0110;
    flag_tab = 8'b0010_1000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus1.valid_in = 1'b1;
      bus1.first_in = i[3];
      bus1.opcode   = i[2];
      bus1.a_in     = i[1];
      bus1.b_in     = i[0];
      @(posedge clk);
      #1;
      idx = i % 8;
      chk("w1_sum", bus1.sum_out, sum_tab[idx]);
      chk("w1_flag", bus1.flag_out, flag_tab[idx]);
      chk("w1_valid", bus1.valid_out, 1);
      chk("w1_last", bus1.last_out, 1);
`ifdef ADD_SUB_OVF_EN
      chk("w1_ovf", bus1.ovf_out, flag_tab[idx]);
`endif
    end
    @(negedge clk);
    bus1.valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("w1_idle_valid", bus1.valid_out, 0);
    chk("w1_idle_last", bus1.last_out, 0);

    // WORD_BITS=8 words
    run_word("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
    run_word("addff01", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    run_word("sub1001", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
    run_word("sub0001", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_word("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1);

    // Opcode toggled mid-word plus a 3-cycle gap after bit 3: still 0x5A+0x3C
    got = '0;
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, i == 0, sum_tab[0] | (8'h5A >> i) & 1'b1, (8'h3C >> i) & 1'b1, i != 0);
      got[i] = bus8.sum_out;
    end
    for (int g = 0; g < 3; g++) begin
      step8(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("gap_valid", bus8.valid_out, 0);
      chk("gap_last", bus8.last_out, 0);
      chk("gap_sum_hold", bus8.sum_out, 0);
      chk("gap_flag_hold", bus8.flag_out, 1);
    end
    for (int i = 4; i < 8; i++) begin
      step8(1'b1, 1'b0, (8'h5A >> i) & 1'b1, (8'h3C >> i) & 1'b1, i[0]);
      chk("gap_last_pos", bus8.last_out, (i == 7));
      got[i] = bus8.sum_out;
    end
    chk("gap_result", got, 8'h96);
    chk("gap_flag", bus8.flag_out, 0);

    // Abort after 4 bits of 0xFF+0xFF, then new word 0x01+0x01
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
      chk("abort_last", bus8.last_out, 0);
    end
    run_word("newword", 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

    // Asynchronous reset mid-word
    for (int i = 0; i < 3; i++) step8(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    chk("prerst_sum", bus8.sum_out, 1);
    chk("prerst_flag", bus8.flag_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", bus8.sum_out, 0);
    chk("midrst_flag", bus8.flag_out, 0);
    chk("midrst_valid", bus8.valid_out, 0);
    chk("midrst_last", bus8.last_out, 0);
    @(negedge clk);
    bus8.valid_in = 1'b0;
    rst_n = 1'b1;
    run_word("postrst", 8'h03, 8'h01, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
